text_console_writer: RTL and testbench

Writer-side companion to the VGA text display. It accepts ASCII characters over a valid/ready stream and drives the write port (data, address, write enable) of the 80×30 text RAM that the display scans. It keeps a cursor and interprets a small set of control codes: LF, CR, BS and FF. It also blanks rows on line advance and blanks the whole screen on FF. It sits between the CPU I/O register (or UART) and the text RAM; the display path is untouched.

---
 rtl/gpu_pkg.sv | 28 ++
 rtl/text_console_writer.sv | 171 +++++++++++++++++
 tb/tb_text_console_writer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg -- constants and types shared by the text display and its writer.
//   COLS_DEF / ROWS_DEF : text screen geometry (80 x 30 character cells)
//   BLANK_DEF           : byte used to clear a cell
//   CH_*                : control codes interpreted by text_console_writer
//   wr_state_e          : text_console_writer FSM states
package gpu_pkg;

   localparam int          COLS_DEF  = 80;
   localparam int          ROWS_DEF  = 30;
   localparam logic [7:0]  BLANK_DEF = 8'h20;

   localparam logic [7:0]  CH_BS = 8'h08;
   localparam logic [7:0]  CH_LF = 8'h0A;
   localparam logic [7:0]  CH_FF = 8'h0C;
   localparam logic [7:0]  CH_CR = 8'h0D;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_CLEAR_LINE   = 2'd1,
      ST_CLEAR_SCREEN = 2'd2
   } wr_state_e;

   // Printable ASCII range, space through tilde.
   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/text_console_writer.sv
// text_console_writer -- turns an ASCII byte stream into writes to the 80x30
// text RAM, keeping a cursor and handling BS, LF, CR and FF.
//   clk, rst            : clock, asynchronous active-high reset
//   char_in/char_valid  : byte stream in; accepted when char_valid && char_ready
//   char_ready          : high only in IDLE
//   w_data/w_addr/w_en  : registered text RAM write port, addr = y*COLS + x
//   cursor_x/cursor_y   : current cursor position
//   busy                : a line or screen clear is in progress
module text_console_writer
   import gpu_pkg::*;
#(
   parameter int         COLS  = COLS_DEF,
   parameter int         ROWS  = ROWS_DEF,
   parameter logic [7:0] BLANK = BLANK_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [7:0]  w_data,
   output logic [11:0] w_addr,
   output logic        w_en,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y,
   output logic        busy
);

   wr_state_e   state_q, state_d;
   logic [6:0]  x_q, x_d;
   logic [4:0]  y_q, y_d;
   logic [11:0] clr_q, clr_d;
   logic        w_en_q, w_en_d;
   logic [11:0] w_addr_q, w_addr_d;
   logic [7:0]  w_data_q, w_data_d;

   logic [4:0]  y_next_s;
   logic [11:0] clr_end_s;
   logic        line_adv_s;

   // Row start address; the default 80-column case is (y<<6)+(y<<4).
   function automatic logic [11:0] row_base(input logic [4:0] y);
      logic [11:0] y12;
      y12 = {7'd0, y};
      if (COLS == 80) begin
         return (y12 << 6) + (y12 << 4);
      end else begin
         return 12'(y12 * 12'(COLS));
      end
   endfunction

   // Next row with wrap to the top (no scrolling).
   assign y_next_s  = (y_q == 5'(ROWS - 1)) ? 5'd0 : y_q + 5'd1;

   // Last address of the clear in progress; cursor_y is stable during a line clear.
   assign clr_end_s = (state_q == ST_CLEAR_SCREEN) ? 12'(COLS * ROWS - 1)
                                                   : row_base(y_q) + 12'(COLS - 1);

   // Next-state, cursor and write-port logic.
   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      clr_d      = clr_q;
      w_en_d     = 1'b0;
      w_addr_d   = w_addr_q;
      w_data_d   = w_data_q;
      line_adv_s = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (char_valid) begin
               if (is_printable(char_in)) begin
                  w_en_d   = 1'b1;
                  w_addr_d = row_base(y_q) + {5'd0, x_q};
                  w_data_d = char_in;
                  if (x_q < 7'(COLS - 1)) begin
                     x_d = x_q + 7'd1;
                  end else begin
                     x_d        = 7'd0;
                     line_adv_s = 1'b1;
                  end
               end else begin
                  case (char_in)
                     CH_LF: begin
                        x_d        = 7'd0;
                        line_adv_s = 1'b1;
                     end
                     CH_CR: begin
                        x_d = 7'd0;
                     end
                     CH_BS: begin
                        // BS stops at column 0; it never reaches the previous row.
                        if (x_q != 7'd0) begin
                           x_d      = x_q - 7'd1;
                           w_en_d   = 1'b1;
                           w_addr_d = row_base(y_q) + {5'd0, x_q} - 12'd1;
                           w_data_d = BLANK;
                        end else begin
                           x_d = x_q;
                        end
                     end
                     CH_FF: begin
                        x_d     = 7'd0;
                        y_d     = 5'd0;
                        clr_d   = 12'd0;
                        state_d = ST_CLEAR_SCREEN;
                     end
                     default: begin
                        state_d = ST_IDLE;
                     end
                  endcase
               end
               if (line_adv_s) begin
                  y_d     = y_next_s;
                  clr_d   = row_base(y_next_s);
                  state_d = ST_CLEAR_LINE;
               end else begin
                  y_d = y_d;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
            w_en_d   = 1'b1;
            w_addr_d = clr_q;
            w_data_d = BLANK;
            // Stop on the end address rather than letting the counter wrap.
            if (clr_q == clr_end_s) begin
               state_d = ST_IDLE;
            end else begin
               clr_d = clr_q + 12'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, cursor, clear counter and write-port registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         x_q      <= 7'd0;
         y_q      <= 5'd0;
         clr_q    <= 12'd0;
         w_en_q   <= 1'b0;
         w_addr_q <= 12'd0;
         w_data_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         clr_q    <= clr_d;
         w_en_q   <= w_en_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
      end
   end

   assign char_ready = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign cursor_x   = x_q;
   assign cursor_y   = y_q;
   assign w_en       = w_en_q;
   assign w_addr     = w_addr_q;
   assign w_data     = w_data_q;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [7:0]  w_data;
   logic [11:0] w_addr;
   logic        w_en;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   text_console_writer dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .w_data     (w_data),
      .w_addr     (w_addr),
      .w_en       (w_en),
      .cursor_x   (cursor_x),
      .cursor_y   (cursor_y),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct { int t; int a; int d; } wr_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   wr_t  obs_q[$];
   wr_t  exp_q[$];
   logic [7:0] ram [0:4095];   // image built from observed DUT writes
   logic [7:0] scr [0:2399];   // reference screen
   int   mx = 0;
   int   my = 0;

   // Posedge counter used as a timestamp for every write.
   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: record each presented write.
   always @(negedge clk) begin
      if (w_en === 1'b1) begin
         obs_q.push_back('{cyc, int'(w_addr), int'(w_data)});
         ram[w_addr] = w_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input int t, input int a, input int d);
      exp_q.push_back('{t, a, d});
   endtask

   // Reference: writes and cursor motion for one byte accepted at edge k.
   task automatic model_byte(input logic [7:0] c, input int k);
      bit adv = 0;
      if (c >= 8'h20 && c <= 8'h7E) begin
         push_exp(k, my * 80 + mx, int'(c));
         if (mx < 79) mx++;
         else begin mx = 0; adv = 1; end
      end else if (c == 8'h0A) begin
         mx = 0; adv = 1;
      end else if (c == 8'h0D) begin
         mx = 0;
      end else if (c == 8'h08) begin
         if (mx > 0) begin
            mx--;
            push_exp(k, my * 80 + mx, 32'h20);
         end
      end else if (c == 8'h0C) begin
         mx = 0; my = 0;
         for (int i = 0; i < 2400; i++) push_exp(k + 1 + i, i, 32'h20);
      end
      if (adv) begin
         my = (my + 1) % 30;
         for (int i = 0; i < 80; i++) push_exp(k + 1 + i, my * 80 + i, 32'h20);
      end
   endtask

   // Present a byte (called #1 after a posedge), hold until accepted.
   task automatic send(input logic [7:0] c, output int acc);
      int n = 0;
      char_in    = c;
      char_valid = 1'b1;
      while (char_ready !== 1'b1 && n < 5000) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_timeout", (n < 5000), 1);
      @(posedge clk); #1;
      acc        = cyc;
      char_valid = 1'b0;
      model_byte(c, acc);
   endtask

   task automatic compare_writes();
      int n;
      wr_t e, o;
      chk("write_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q[i];
         o = obs_q[i];
         chk("write_cycle", o.t, e.t);
         chk("write_addr",  o.a, e.a);
         chk("write_data",  o.d, e.d);
         scr[e.a] = e.d[7:0];
      end
      exp_q.delete();
      obs_q.delete();
   endtask

   // Wait for IDLE, let the last write be seen, compare writes and cursor.
   task automatic sync(output int waited);
      waited = 0;
      while (char_ready !== 1'b1 && waited < 5000) begin
         @(posedge clk); #1; waited++;
      end
      chk("idle_timeout", (waited < 5000), 1);
      @(negedge clk); #1;
      compare_writes();
      chk("cursor_x", cursor_x, mx);
      chk("cursor_y", cursor_y, my);
      @(posedge clk); #1;
   endtask

   initial begin
      int acc, w, n, bad;
      logic [7:0] c;
      string s;

      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      for (int i = 0; i < 2400; i++) scr[i] = 8'h00;
      rst = 1'b1; char_valid = 1'b0; char_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_w_en", w_en, 0);
      chk("rst_w_addr", w_addr, 0);
      chk("rst_w_data", w_data, 0);
      chk("rst_cursor_x", cursor_x, 0);
      chk("rst_cursor_y", cursor_y, 0);
      chk("rst_ready", char_ready, 1);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_ready", char_ready, 1);
      chk("post_rst_w_en", w_en, 0);

      // "AB" back to back: ready stays high.
      send(8'h41, acc);
      chk("ab_ready_a", char_ready, 1);
      send(8'h42, w);
      chk("ab_ready_b", char_ready, 1);
      chk("ab_consecutive", w - acc, 1);
      sync(w);
      chk("ab_x", cursor_x, 2);

      // FF: 2400 ascending blanks, ready low 2400 cycles, stray valid ignored.
      send(8'h0C, acc);
      n = 0;
      while (char_ready !== 1'b1 && n < 5000) begin
         if (n == 500) begin char_in = 8'h51; char_valid = 1'b1; end
         else char_valid = 1'b0;
         if (n == 100) chk("ff_busy", busy, 1);
         @(posedge clk); #1; n++;
      end
      char_valid = 1'b0;
      chk("ff_ready_low_cycles", n, 2400);
      sync(w);

      // 80 'x' from (0,0): wrap, clear row 1 at 80..159.
      for (int i = 0; i < 80; i++) send(8'h78, acc);
      sync(w);
      chk("wrap_ready_low_cycles", w, 80);
      chk("wrap_y", cursor_y, 1);

      // Reach (5,29) then LF: blanks 0..79, cursor (0,0).
      for (int i = 0; i < 28; i++) begin send(8'h0A, acc); sync(w); end
      for (int i = 0; i < 5; i++) send(8'h2E, acc);
      sync(w);
      chk("lf_pre_pos", {cursor_y, cursor_x}, {5'd29, 7'd5});
      send(8'h0A, acc);
      sync(w);
      chk("lf_ready_low_cycles", w, 80);

      // (3,2) BS writes 162, then BS at column 0 does nothing.
      send(8'h0A, acc); sync(w);
      send(8'h0A, acc); sync(w);
      s = "abc";
      for (int i = 0; i < 3; i++) send(s[i], acc);
      send(8'h08, acc);
      sync(w);
      chk("bs_addr", ram[162], 8'h20);
      chk("bs_pos", {cursor_y, cursor_x}, {5'd2, 7'd2});
      send(8'h0D, acc);
      send(8'h08, acc);
      sync(w);
      chk("bs_col0_pos", {cursor_y, cursor_x}, {5'd2, 7'd0});

      // Reset at the 1000th FF write.
      send(8'h0C, acc);
      repeat (1000) @(posedge clk);
      #1;
      chk("ff1000_w_en", w_en, 1);
      chk("ff1000_w_addr", w_addr, 999);
      rst = 1'b1;
      #1;
      chk("abort_w_en", w_en, 0);
      chk("abort_cursor", {cursor_y, cursor_x}, 0);
      chk("abort_ready", char_ready, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_ready_after", char_ready, 1);
      chk("abort_partial_count", obs_q.size(), 999);
      while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
      compare_writes();
      mx = 0; my = 0;
      send(8'h5A, acc);
      sync(w);
      chk("z_at_0", ram[0], 8'h5A);

      // Randomized mix of printables and control codes.
      for (int i = 0; i < 400; i++) begin
         n = $urandom_range(0, 99);
         if (n < 70)      c = 8'($urandom_range(32'h20, 32'h7E));
         else if (n < 77) c = 8'h0A;
         else if (n < 83) c = 8'h0D;
         else if (n < 93) c = 8'h08;
         else if (n < 99) begin
            c = 8'($urandom_range(0, 255));
            if ((c >= 8'h20 && c <= 8'h7E) || c == 8'h0A || c == 8'h0D ||
                c == 8'h08 || c == 8'h0C) c = 8'h1B;
         end
         else c = 8'h0C;
         send(c, acc);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         if (i % 8 == 7) sync(w);
      end
      sync(w);

      bad = 0;
      for (int i = 0; i < 2400; i++) if (ram[i] !== scr[i]) bad++;
      chk("screen_image", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
